// File: rtl/fifo_drain_pkg.sv
// Shared types and default widths for the fifo_drain consumer stage.
// Optional frame checksum is enabled by defining FIFO_DRAIN_CSUM_EN.
package fifo_drain_pkg;

  localparam int FIFO_DRAIN_BUSW = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [FIFO_DRAIN_BUSW-1:0] data;
    logic                       last;
  } drain_entry_t;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry skid buffer holding {data, last} words; entry 0 is always the head.
// Occupancy is the FSM state and is exported on occ_dbg.
module drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int W = FIFO_DRAIN_BUSW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         last,
  output logic [1:0]   occ_dbg
);

  // Stream handshake: a word transfers on each rising edge where valid && ready;
  // valid never depends on ready, and data/last hold while valid is high and ready low.
  occ_e         state_q;
  occ_e         state_d;
  logic         pop;
  logic [W-1:0] data_q [2];
  logic         last_q [2];

  assign pop = valid && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= OCC_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (push) state_d = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_d = OCC_TWO;
        else if (!push && pop) state_d = OCC_EMPTY;
      end
      OCC_TWO: if (pop && !push) state_d = OCC_ONE;
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_comb begin
    full    = (state_q == OCC_TWO);
    valid   = (state_q != OCC_EMPTY);
    data    = valid ? data_q[0] : '0;
    last    = valid && last_q[0];
    occ_dbg = state_q;
  end

  // Pops shift entry 1 into the head slot; pushes fill the first free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            data_q[0] <= push_data;
            last_q[0] <= push_last;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            data_q[0] <= push_data;
            last_q[0] <= push_last;
          end else if (push) begin
            data_q[1] <= push_data;
            last_q[1] <= push_last;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            data_q[0] <= data_q[1];
            last_q[0] <= last_q[1];
            if (push) begin
              data_q[1] <= push_data;
              last_q[1] <= push_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Drains a show-ahead FIFO into a valid/ready stream with frame tagging and a word counter.
// Define FIFO_DRAIN_CSUM_EN to add the per-frame XOR checksum on csum/csum_valid.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int BUSW      = FIFO_DRAIN_BUSW,
  parameter int FRAME_LEN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            fifo_empty,
  input  logic [BUSW-1:0] fifo_dataout,
  output logic            fifo_pull,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BUSW-1:0] out_data,
  output logic            out_last,
  output logic [31:0]     word_cnt,
  output logic [BUSW-1:0] csum,
  output logic            csum_valid,
  output logic [1:0]      dbg_occ
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic        full;
  logic        accept;
  logic        push_last;
  logic [15:0] fidx_q;
  logic [31:0] word_cnt_q;

  // Pull depends only on registered occupancy and FIFO flags, never on out_ready.
  assign fifo_pull = rst && enable && !fifo_empty && !full;
  assign accept    = out_valid && out_ready;
  assign push_last = (fidx_q == LAST_IDX);
  assign word_cnt  = word_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           fidx_q <= '0;
    else if (fifo_pull) fidx_q <= push_last ? 16'd0 : fidx_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        word_cnt_q <= '0;
    else if (accept) word_cnt_q <= word_cnt_q + 32'd1;
  end

  drain_skid_buf #(.W(BUSW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_pull),
    .push_data (fifo_dataout),
    .push_last (push_last),
    .full      (full),
    .valid     (out_valid),
    .ready     (out_ready),
    .data      (out_data),
    .last      (out_last),
    .occ_dbg   (dbg_occ)
  );

`ifdef FIFO_DRAIN_CSUM_EN
  logic [BUSW-1:0] acc_q;
  logic [BUSW-1:0] csum_q;
  logic            csum_valid_q;

  // The closing word of a frame folds into csum directly and restarts the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      csum_valid_q <= accept && out_last;
      if (accept) begin
        if (out_last) begin
          csum_q <= acc_q ^ out_data;
          acc_q  <= '0;
        end else begin
          acc_q  <= acc_q ^ out_data;
        end
      end
    end
  end

  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;
`else
  assign csum       = '0;
  assign csum_valid = 1'b0;
`endif

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Downstream consumer stage for the test-bench FIFO. Pulls words from the FIFO's show-ahead read port (`dataout` valid whenever `empty` is low; tail advances on the clock edge that samples `pull`). Re-emits them on a valid/ready stream through a 2-entry skid buffer, tags frame boundaries every `FRAME_LEN` words, and counts delivered words. Sits between the FIFO and the bench's monitor/scoreboard or any downstream sink.

## Interface
- `BUSW`, 32, data width; must match FIFO `busw`.
- `FRAME_LEN`, 8, words per frame; legal range 1..65535.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new pulls from the FIFO; does not block draining of buffered words.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dataout`  in  BUSW  FIFO head word, show-ahead.
- `fifo_pull`  out  1  pop request to FIFO.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  sink accepts word.
- `out_data`  out  BUSW  output word.
- `out_last`  out  1  current output word is last of a frame.
- `word_cnt`  out  32  total accepted output transfers.
- `csum`  out  BUSW  frame XOR checksum (only with `FIFO_DRAIN_CSUM_EN`).
- `csum_valid`  out  1  one-cycle strobe qualifying `csum` (only with `FIFO_DRAIN_CSUM_EN`).

## Operation
- Buffer occupancy state: EMPTY (0), ONE (1), TWO (2). Transitions are driven by push (`fifo_pull`) and pop (`out_valid && out_ready`): push only gives +1, pop only gives -1, push and pop together leave it unchanged.
- `fifo_pull = enable && !fifo_empty && occ != TWO`. It is a combinational function of registered state and FIFO flags only, never of `out_ready`.
- On a pull, `fifo_dataout` is captured at the same edge, tagged with the frame index `fidx` (0..FRAME_LEN-1). `fidx` increments per pull and wraps FRAME_LEN-1 → 0.
- `out_valid = (occ != EMPTY)`. `out_data` and `out_last` come from the head entry. `out_last = (head tag == FRAME_LEN-1)`. With FRAME_LEN=1, every word is last.
- Sink rule: once `out_valid` is high, `out_data` and `out_last` stay stable until accepted.
- `word_cnt` increments by 1 per accepted transfer and wraps from 2^32-1 to 0.
- `enable` low: no pulls; buffered entries still drain. `fidx` is retained across enable toggles.
- Overflow/underflow are impossible by construction. Bench asserts that occ never exceeds 2 and that there is no pop while EMPTY.

## Timing
- Reset (rst low, asynchronous): occ=EMPTY, `fidx`=0, `word_cnt`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `fifo_pull`=0 (forced low while reset is asserted), `csum`=0, `csum_valid`=0. Buffered words are discarded.
- Latency: word pulled at edge N appears on `out_data` with `out_valid`=1 in cycle N+1.
- Throughput: 1 word/cycle sustained with `out_ready` held high and FIFO non-empty (occ stays ONE).
- `out_ready` low for k cycles: at most 2 words are pulled, then `fifo_pull` drops. Pulls resume in the cycle after the first acceptance frees a slot.
- `fifo_empty` high: no pull. The buffer drains normally.

## Configuration
- `FIFO_DRAIN_CSUM_EN` defined:
  - Accumulator XORs `out_data` on each accepted transfer.
  - On acceptance of an `out_last` word, `csum` is loaded with the accumulator XOR that word at the next edge, and `csum_valid` pulses for exactly one cycle. The accumulator is then cleared.
  - Reset clears the accumulator.
- Not defined: no accumulator. `csum` and `csum_valid` are tied to 0; the ports remain present.

## Structure
- Package `fifo_drain_pkg` holds:
  - occupancy enum `occ_e` {OCC_EMPTY, OCC_ONE, OCC_TWO};
  - struct `drain_entry_t` {data, last};
  - default width constant `FIFO_DRAIN_BUSW=32`.
- One sub-module: `drain_skid_buf`, the 2-entry tagged buffer with occupancy state. The top level holds `fidx`, `word_cnt`, the checksum logic and `fifo_pull` generation.

## Test plan
- Reset, then FIFO holds 0x11,0x22,0x33 with `out_ready`=1, `enable`=1 → `fifo_pull` high for 3 cycles; `out_data` 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after its pull; `word_cnt`=3.
- FIFO full of 10 words, `out_ready`=0 for 6 cycles → exactly 2 pulls, then `fifo_pull`=0 and `out_data` holds 1st word. Release `out_ready` → all 10 words delivered in order.
- FRAME_LEN=4, send 0x1,0x2,0x4,0x8,0x10 → `out_last` only on 0x8. With macro: `csum`=0xF and `csum_valid` pulses once, the cycle after 0x8 is accepted.
- `enable` dropped with occ=TWO → both words drain, no further pulls. Re-enable → frame index continues from where it stopped.
- rst asserted mid-frame with occ=TWO → all outputs 0 immediately; after release, next word has `fidx`=0 and `word_cnt` restarts from 0.
- Preload `word_cnt` to 0xFFFFFFFF via force, accept one word → `word_cnt`=0.
